// File: rtl/bus_pkg.sv
// Shared constants and types for the CPU-to-peripheral interconnect.
package bus_pkg;

    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REGION_MSB = 31;
    localparam int unsigned REGION_W   = 3;

    localparam logic [DATA_W-1:0] ERR_RVALUE = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ERR
    } bus_state_e;

endpackage

// File: rtl/bus_interconnect_if.sv
// Master-side and target-side bus signals of the interconnect, grouped with per-role modports.
interface bus_interconnect_if
    import bus_pkg::*;
#(
    parameter int unsigned NTGT = 4
);

    logic                   m_enable_i;
    logic [3:0]             m_wstrb_i;
    logic [ADDR_W-1:0]      m_addr_i;
    logic [DATA_W-1:0]      m_wvalue_i;
    logic [DATA_W-1:0]      m_rvalue_o;
    logic                   m_ready_o;
    logic                   m_err_o;

    logic [NTGT-1:0]        t_enable_o;
    logic [3:0]             t_wstrb_o;
    logic [ADDR_W-1:0]      t_addr_o;
    logic [DATA_W-1:0]      t_wvalue_o;
    logic [NTGT*DATA_W-1:0] t_rvalue_i;
    logic [NTGT-1:0]        t_ready_i;

    // CPU view: issues requests, receives completions.
    modport master (
        output m_enable_i, m_wstrb_i, m_addr_i, m_wvalue_i,
        input  m_rvalue_o, m_ready_o, m_err_o
    );

    // Interconnect view: slave to the CPU, drives the target side.
    modport slave (
        input  m_enable_i, m_wstrb_i, m_addr_i, m_wvalue_i, t_rvalue_i, t_ready_i,
        output m_rvalue_o, m_ready_o, m_err_o, t_enable_o, t_wstrb_o, t_addr_o, t_wvalue_o
    );

    modport target (
        input  t_enable_o, t_wstrb_o, t_addr_o, t_wvalue_o,
        output t_rvalue_i, t_ready_i
    );

endinterface

// File: rtl/bus_watchdog.sv
// Wait-cycle counter for a pending target access; flags expiry when it reaches TIMEOUT.
module bus_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q;

    // Holding at Limit keeps the counter from ever wrapping; with TIMEOUT=0 it stays at zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (run_i && (cnt_q != Limit)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (TIMEOUT != 0) && (cnt_q == Limit);

endmodule

// File: rtl/bus_interconnect.sv
// Region decode, target handshake, read mux, timeout error and sticky error log.
module bus_interconnect
    import bus_pkg::*;
#(
    parameter int unsigned NTGT    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    bus_interconnect_if.slave bus,
    output logic [7:0]        err_count_o,
    output logic [ADDR_W-1:0] err_addr_o
);

    localparam logic [REGION_W:0] NtgtLim = NTGT[REGION_W:0];

    bus_state_e          state_q;
    logic [REGION_W-1:0] tgt_q;
    logic [7:0]          err_count_q;
    logic [ADDR_W-1:0]   err_addr_q;

    logic [REGION_W-1:0] region;
    logic                mapped;
    logic                sel_ready;
    logic [DATA_W-1:0]   sel_rvalue;
    logic                wd_clear;
    logic                wd_run;
    logic                wd_expired;

    logic [NTGT-1:0]     t_enable;
    logic                m_ready;
    logic                m_err;
    logic [DATA_W-1:0]   m_rvalue;

    assign region = bus.m_addr_i[REGION_MSB -: REGION_W];
    assign mapped = {1'b0, region} < NtgtLim;

    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalue = '0;
        for (int k = 0; k < NTGT; k++) begin
            if (tgt_q == REGION_W'(k)) begin
                sel_ready  = bus.t_ready_i[k];
                sel_rvalue = bus.t_rvalue_i[k*DATA_W +: DATA_W];
            end
        end
    end

    bus_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .clear_i   (wd_clear),
        .run_i     (wd_run),
        .expired_o (wd_expired)
    );

    always_comb begin
        t_enable = '0;
        m_ready  = 1'b0;
        m_err    = 1'b0;
        m_rvalue = '0;
        wd_clear = 1'b0;
        wd_run   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.m_enable_i && mapped) begin
                    for (int k = 0; k < NTGT; k++) begin
                        t_enable[k] = (region == REGION_W'(k));
                    end
                    wd_clear = 1'b1;
                end
            end
            WAIT: begin
                // Ready has priority over an expiry in the same cycle.
                if (sel_ready) begin
                    m_ready  = 1'b1;
                    m_rvalue = sel_rvalue;
                end else if (wd_expired) begin
                    m_ready  = 1'b1;
                    m_err    = 1'b1;
                    m_rvalue = ERR_RVALUE;
                end else begin
                    wd_run = 1'b1;
                end
            end
            ERR: begin
                m_ready  = 1'b1;
                m_err    = 1'b1;
                m_rvalue = ERR_RVALUE;
            end
            default: ;
        endcase
        // Outputs are forced low while reset is held, even with a request pending.
        if (!rstn_i) begin
            t_enable = '0;
            m_ready  = 1'b0;
            m_err    = 1'b0;
            m_rvalue = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            err_count_q <= '0;
            err_addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.m_enable_i) begin
                        if (mapped) begin
                            tgt_q   <= region;
                            state_q <= WAIT;
                        end else begin
                            state_q <= ERR;
                        end
                    end
                end
                WAIT:    if (m_ready) state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
            if (m_ready && m_err) begin
                if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'd1;
                err_addr_q <= bus.m_addr_i;
            end
        end
    end

    assign bus.t_enable_o = t_enable;
    assign bus.m_ready_o  = m_ready;
    assign bus.m_err_o    = m_err;
    assign bus.m_rvalue_o = m_rvalue;
    assign bus.t_addr_o   = bus.m_addr_i;
    assign bus.t_wstrb_o  = bus.m_wstrb_i;
    assign bus.t_wvalue_o = bus.m_wvalue_i;
    assign err_count_o    = err_count_q;
    assign err_addr_o     = err_addr_q;

endmodule
